// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: FSM state encoding, default frame
// constants and the parity comparison helper.
package uart_rx_pkg;

    // Default frame shape; the transmit side uses the same values.
    localparam int unsigned DEF_DATA_BITS  = 8;
    localparam int unsigned DEF_OVERSAMPLE = 16;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // A set result means the received parity bit disagrees with the data.
    function automatic logic parity_mismatch(
        input logic data_xor,
        input logic sample,
        input logic odd
    );
        return data_xor ^ sample ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a
// falling-edge detector on the synchronized value.
//
// Ports:
//   fast_clock  system clock
//   rst         asynchronous active-low reset (all flops reset to 1 = idle line)
//   rx_in       raw asynchronous serial line
//   rx_s        synchronized line value
//   rx_fall     high while the synchronized line has just gone 1 -> 0
module uart_rx_sync (
    input  logic fast_clock,
    input  logic rst,
    input  logic rx_in,
    output logic rx_s,
    output logic rx_fall
);

    logic rx_meta;
    logic rx_prev;

    // Reset to 1 so that a line already low at reset release looks like an edge
    // only after it has been seen high.
    always_ff @(posedge fast_clock or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Edge is a decode of two flops, so it has no extra latency.
    assign rx_fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// UART receiver. Recovers asynchronous frames (start, DATA_BITS data bits
// LSB first, optional parity, one stop bit) from rx_in. All timing advances on
// tick, which pulses OVERSAMPLE times per bit. OVERSAMPLE must be even and >= 4.
//
// Ports:
//   fast_clock  system clock
//   rst         asynchronous active-low reset
//   tick        oversample enable, one fast_clock cycle wide
//   rx_in       asynchronous serial line, idle high
//   rx_data     last received word, held until the next rx_valid
//   rx_valid    one-cycle pulse when a frame completes
//   frame_err   pulse with rx_valid when the stop bit sampled 0
//   parity_err  pulse with rx_valid when the parity check failed
//   busy        high whenever the receiver is not idle
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 fast_clock,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] END_CNT  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_fall;

    rx_state_e            state;
    rx_state_e            state_next;

    logic [CNT_W-1:0]     sample_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_flag;

    logic                 mid_c;
    logic                 end_c;
    logic                 last_bit_c;

    logic                 cnt_clr_c;
    logic                 cnt_inc_c;
    logic                 bit_clr_c;
    logic                 bit_inc_c;
    logic                 shift_c;
    logic                 par_clr_c;
    logic                 par_load_c;
    logic                 deliver_c;

    // Line synchronizer and start-edge detector.
    uart_rx_sync u_sync (
        .fast_clock (fast_clock),
        .rst        (rst),
        .rx_in      (rx_in),
        .rx_s       (rx_s),
        .rx_fall    (rx_fall)
    );

    // Sample points: mid-start uses half a bit; every later bit is sampled a
    // full bit after the previous sample, i.e. also mid-bit.
    assign mid_c      = tick && (sample_cnt == MID_CNT);
    assign end_c      = tick && (sample_cnt == END_CNT);
    assign last_bit_c = (bit_cnt == LAST_BIT);

    // State register.
    always_ff @(posedge fast_clock or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (rx_fall) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (mid_c) begin
                    // A line back high at mid-start was a glitch, not a frame.
                    state_next = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (end_c && last_bit_c) begin
                    state_next = PARITY_EN ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (end_c) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                // Idle from mid-stop so a back-to-back start edge is not missed.
                if (end_c) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath control strobes per state.
    always_comb begin
        cnt_clr_c  = 1'b0;
        cnt_inc_c  = 1'b0;
        bit_clr_c  = 1'b0;
        bit_inc_c  = 1'b0;
        shift_c    = 1'b0;
        par_clr_c  = 1'b0;
        par_load_c = 1'b0;
        deliver_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_fall) begin
                    cnt_clr_c = 1'b1;
                    par_clr_c = 1'b1;
                end
            end
            ST_START: begin
                if (mid_c) begin
                    cnt_clr_c = 1'b1;
                    bit_clr_c = 1'b1;
                end else begin
                    cnt_inc_c = tick;
                end
            end
            ST_DATA: begin
                if (end_c) begin
                    shift_c   = 1'b1;
                    cnt_clr_c = 1'b1;
                    bit_inc_c = 1'b1;
                end else begin
                    cnt_inc_c = tick;
                end
            end
            ST_PARITY: begin
                if (end_c) begin
                    par_load_c = 1'b1;
                    cnt_clr_c  = 1'b1;
                end else begin
                    cnt_inc_c = tick;
                end
            end
            ST_STOP: begin
                if (end_c) begin
                    deliver_c = 1'b1;
                end else begin
                    cnt_inc_c = tick;
                end
            end
            default: begin
                cnt_clr_c = 1'b1;
            end
        endcase
    end

    // Counters, shift register and parity flag.
    always_ff @(posedge fast_clock or negedge rst) begin
        if (!rst) begin
            sample_cnt  <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            parity_flag <= 1'b0;
        end else begin
            if (cnt_clr_c) begin
                sample_cnt <= '0;
            end else if (cnt_inc_c) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end

            if (bit_clr_c) begin
                bit_cnt <= '0;
            end else if (bit_inc_c) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end

            // LSB arrives first, so shifting right leaves it at bit 0.
            if (shift_c) begin
                shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            end

            if (par_clr_c) begin
                parity_flag <= 1'b0;
            end else if (par_load_c) begin
                parity_flag <= parity_mismatch(^shift_reg, rx_s, PARITY_ODD);
            end
        end
    end

    // Output registers; pulses last exactly one cycle after the stop sample.
    always_ff @(posedge fast_clock or negedge rst) begin
        if (!rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (deliver_c) begin
                rx_data <= shift_reg;
            end
            rx_valid   <= deliver_c;
            frame_err  <= deliver_c & ~rx_s;
            parity_err <= deliver_c & parity_flag & PARITY_EN;
            busy       <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 instance and an 8E1 instance share clock, reset
// and tick. The frame sender records what each completed frame must deliver;
// a per-cycle monitor checks every output against that record.
module tb_uart_rx;

    logic       fast_clock = 1'b0;
    logic       rst        = 1'b0;
    logic       tick       = 1'b0;
    logic       rx0        = 1'b1;
    logic       rx1        = 1'b1;

    logic [7:0] d0, d1;
    logic       v0, v1, fe0, fe1, pe0, pe1, b0, b1;

    int         n_chk  = 0;
    int         n_pass = 0;
    int         tick_div = 1;
    int         tcnt     = 0;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t       exp_q0[$];
    exp_t       exp_q1[$];
    logic [7:0] last_d[2];
    int         vcount[2];
    logic       cap_fe[2];
    logic       cap_pe[2];

    uart_rx #(
        .DATA_BITS (8),
        .OVERSAMPLE(16),
        .PARITY_EN (1'b0),
        .PARITY_ODD(1'b0)
    ) dut (
        .fast_clock(fast_clock),
        .rst       (rst),
        .tick      (tick),
        .rx_in     (rx0),
        .rx_data   (d0),
        .rx_valid  (v0),
        .frame_err (fe0),
        .parity_err(pe0),
        .busy      (b0)
    );

    uart_rx #(
        .DATA_BITS (8),
        .OVERSAMPLE(16),
        .PARITY_EN (1'b1),
        .PARITY_ODD(1'b0)
    ) dut_p (
        .fast_clock(fast_clock),
        .rst       (rst),
        .tick      (tick),
        .rx_in     (rx1),
        .rx_data   (d1),
        .rx_valid  (v1),
        .frame_err (fe1),
        .parity_err(pe1),
        .busy      (b1)
    );

    always #5 fast_clock = ~fast_clock;

    // Baud prescaler stand-in: one tick every tick_div cycles.
    initial begin
        forever begin
            @(posedge fast_clock);
            #1;
            tcnt = (tcnt + 1 >= tick_div) ? 0 : tcnt + 1;
            tick = (tcnt == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge fast_clock);
            #1;
        end
    endtask

    task automatic set_line(input int w, input logic v);
        if (w == 0) rx0 = v;
        else        rx1 = v;
    endtask

    // Per-cycle check of one receiver against the expected-frame record.
    task automatic mon_port(input int w, input logic v, input logic [7:0] d,
                            input logic fe, input logic pe);
        exp_t e;
        int   qs;
        qs = (w == 0) ? exp_q0.size() : exp_q1.size();
        if (v) begin
            if (qs == 0) begin
                chk($sformatf("unexpected rx_valid port%0d", w), 32'(v), 32'd0);
            end else begin
                e = (w == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                chk($sformatf("rx_data port%0d", w), 32'(d), 32'(e.data));
                chk($sformatf("frame_err port%0d", w), 32'(fe), 32'(e.fe));
                chk($sformatf("parity_err port%0d", w), 32'(pe), 32'(e.pe));
                last_d[w] = e.data;
                vcount[w]++;
                cap_fe[w] = fe;
                cap_pe[w] = pe;
            end
        end else begin
            chk($sformatf("frame_err idle port%0d", w), 32'(fe), 32'd0);
            chk($sformatf("parity_err idle port%0d", w), 32'(pe), 32'd0);
            chk($sformatf("rx_data hold port%0d", w), 32'(d), 32'(last_d[w]));
        end
    endtask

    // Monitor: every cycle, away from the active edge.
    always @(negedge fast_clock) begin
        if (!rst) begin
            chk("reset rx_valid", {31'd0, v0 | v1}, 32'd0);
            chk("reset errs", {30'd0, fe0 | fe1, pe0 | pe1}, 32'd0);
            chk("reset rx_data", {16'd0, d0, d1}, 32'd0);
            chk("reset busy", {31'd0, b0 | b1}, 32'd0);
            last_d[0] = 8'h00;
            last_d[1] = 8'h00;
        end else begin
            mon_port(0, v0, d0, fe0, pe0);
            mon_port(1, v1, d1, fe1, pe1);
        end
    end

    // Sends one frame; abort_bit >= 0 resets the receivers at that data bit.
    task automatic send_frame(input int w, input logic [7:0] d, input logic stop_bit,
                              input logic par_on, input logic par_bit, input int abort_bit);
        int   bc;
        exp_t e;
        bc = 16 * tick_div;
        set_line(w, 1'b0);
        cyc(bc);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_bit) begin
                rst = 1'b0;
                set_line(w, 1'b1);
                cyc(4);
                chk("abort rx_valid", 32'(v0), 32'd0);
                chk("abort rx_data", 32'(d0), 32'd0);
                chk("abort busy", 32'(b0), 32'd0);
                rst = 1'b1;
                cyc(2 * bc);
                return;
            end
            set_line(w, d[i]);
            cyc(bc);
        end
        if (par_on) begin
            set_line(w, par_bit);
            cyc(bc);
        end
        e.data = d;
        e.fe   = ~stop_bit;
        e.pe   = par_on ? (^d ^ par_bit) : 1'b0;
        if (w == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        set_line(w, stop_bit);
        cyc(bc);
    endtask

    initial begin
        int n;
        vcount[0] = 0;
        vcount[1] = 0;
        cap_fe[0] = 1'b0;
        cap_fe[1] = 1'b0;
        cap_pe[0] = 1'b0;
        cap_pe[1] = 1'b0;
        last_d[0] = 8'h00;
        last_d[1] = 8'h00;

        rst = 1'b0;
        cyc(3);
        chk("reset d0", 32'(d0), 32'd0);
        chk("reset busy0", 32'(b0), 32'd0);
        rst = 1'b1;
        cyc(5);

        // 8N1 frame 0xA5.
        send_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0, -1);
        cyc(32);
        chk("A5 count", 32'(vcount[0]), 32'd1);
        chk("A5 data", 32'(d0), 32'hA5);
        chk("A5 errs", {30'd0, cap_fe[0], cap_pe[0]}, 32'd0);
        chk("A5 busy idle", 32'(b0), 32'd0);

        // False start: 3 low ticks; busy must fall right after the 8th tick.
        set_line(0, 1'b0);
        cyc(3);
        set_line(0, 1'b1);
        cyc(1);
        chk("false start busy", 32'(b0), 32'd1);
        n = 0;
        while (b0 && n < 40) begin
            cyc(1);
            n++;
        end
        chk("false start busy drop cycles", 32'(n), 32'd7);
        cyc(20);
        chk("false start no pulse", 32'(vcount[0]), 32'd1);

        // Framing error with the line held low afterwards (break).
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, -1);
        cyc(40);
        chk("break no new frame", 32'(b0), 32'd0);
        chk("3C count", 32'(vcount[0]), 32'd2);
        chk("3C frame_err", 32'(cap_fe[0]), 32'd1);
        chk("3C data", 32'(d0), 32'h3C);
        set_line(0, 1'b1);
        cyc(32);
        send_frame(0, 8'h55, 1'b1, 1'b0, 1'b0, -1);
        cyc(32);
        chk("55 count", 32'(vcount[0]), 32'd3);
        chk("55 data", 32'(d0), 32'h55);
        chk("55 frame_err", 32'(cap_fe[0]), 32'd0);

        // Even parity: 0x07 needs parity bit 1.
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b0, -1);
        cyc(32);
        chk("par bad count", 32'(vcount[1]), 32'd1);
        chk("par bad flag", 32'(cap_pe[1]), 32'd1);
        chk("par bad data", 32'(d1), 32'h07);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, -1);
        cyc(32);
        chk("par good count", 32'(vcount[1]), 32'd2);
        chk("par good flag", 32'(cap_pe[1]), 32'd0);

        // Back-to-back frames with no idle bits.
        send_frame(0, 8'h00, 1'b1, 1'b0, 1'b0, -1);
        send_frame(0, 8'hFF, 1'b1, 1'b0, 1'b0, -1);
        cyc(32);
        chk("b2b count", 32'(vcount[0]), 32'd5);
        chk("b2b data", 32'(d0), 32'hFF);
        chk("b2b errs", {30'd0, cap_fe[0], cap_pe[0]}, 32'd0);

        // Reset during data bit 3, then a clean frame.
        send_frame(0, 8'hC3, 1'b1, 1'b0, 1'b0, 3);
        chk("abort no pulse", 32'(vcount[0]), 32'd5);
        send_frame(0, 8'h5A, 1'b1, 1'b0, 1'b0, -1);
        cyc(32);
        chk("5A count", 32'(vcount[0]), 32'd6);
        chk("5A data", 32'(d0), 32'h5A);

        // Sparse ticks: counters must advance only on tick.
        tick_div = 3;
        cyc(10);
        send_frame(0, 8'h96, 1'b1, 1'b0, 1'b0, -1);
        cyc(100);
        chk("slow tick count", 32'(vcount[0]), 32'd7);
        chk("slow tick data", 32'(d0), 32'h96);
        tick_div = 1;
        cyc(10);

        chk("port0 frames outstanding", 32'(exp_q0.size()), 32'd0);
        chk("port1 frames outstanding", 32'(exp_q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
